alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
Shares the single combinational 8-bit ALU between two requesters. Port A is the execute stage; port B is the address/branch helper. Arbitration is round-robin, with an optional bounded lock for A. Each accepted operation passes through a registered issue stage and then a registered response stage. The arbiter masks ALU outputs that are stale for the given opcode, so responses are always clean.

Parameters:
REG_WIDTH, 8, operand/result width
OP_WIDTH, 3, ALU opcode width
LOCK_MAX, 4, maximum consecutive A grants under a_lock while B is waiting (>=1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
a_valid  in  1  A request valid
a_ready  out  1  A request accepted this cycle
a_op  in  OP_WIDTH  A opcode
a_ra  in  REG_WIDTH  A operand a (signed)
a_rb  in  REG_WIDTH  A operand b (signed)
a_lock  in  1  A requests back-to-back grants
b_valid, b_ready, b_op, b_ra, b_rb  as A, for requester B (no lock)
alu_op  out  OP_WIDTH  to ALU op
alu_ra  out  REG_WIDTH  to ALU ra_in
alu_rb  out  REG_WIDTH  to ALU rb_in
alu_res  in  REG_WIDTH  from ALU res_out
alu_car  in  REG_WIDTH  from ALU car_out
alu_zero  in  1  from ALU zero
alu_jump  in  1  from ALU jump
rsp_valid  out  1  response valid
rsp_ready  in  1  consumer accepts response
rsp_id  out  1  0 = A, 1 = B
rsp_res  out  REG_WIDTH  result
rsp_car  out  REG_WIDTH  carry/spill
rsp_zero  out  1  zero flag
rsp_jump  out  1  branch taken
busy  out  1  issue_vld | rsp_vld

Behaviour:
- State: issue_vld, issue_id, issue regs (op/ra/rb); rsp_vld plus rsp regs; last_gnt; lock_cnt (width clog2(LOCK_MAX+1)).
- Reset (asynchronous): all valids 0, all data regs 0, last_gnt = 1 (B), lock_cnt = 0. All outputs read 0 while reset is held. In-flight operations are discarded and never delivered.
- advance = ~rsp_vld | rsp_ready. can_accept = ~issue_vld | advance.
- Grant (combinational, only when can_accept):
  - Only one valid: that port is granted.
  - Both valid: the port != last_gnt is granted, except A wins when a_lock=1 and lock_cnt < LOCK_MAX.
- a_ready/b_ready = grant for that port. A ready may depend combinationally on the other port's valid.
- On accept (valid & ready): latch op/ra/rb/id into issue regs, set issue_vld, set last_gnt = id.
- lock_cnt increments on an A accept while a_lock & b_valid. It clears on any B accept or when a_lock=0.
- alu_op/ra/rb are driven from the issue regs (0 when ~issue_vld).
- On an edge with issue_vld & advance, the ALU outputs are captured into the rsp regs and rsp_vld is set. If no new accept occurs that edge, issue_vld clears.
- Latency: accept edge -> response visible after the next edge (2 edges). Throughput is 1 op/cycle when rsp_ready stays high.
- Masking at capture:
  - rsp_car = alu_car for ops 3, 4, 5; otherwise 0.
  - rsp_jump = alu_jump for op 6; otherwise 0.
  - rsp_res = 0 for op 6; otherwise alu_res.
  - rsp_zero = (rsp_res == 0) after masking.
- rsp_valid & ~rsp_ready: all rsp_* outputs hold stable. The issue stage holds, and both readys drop once issue_vld=1.
- rsp_vld clears on rsp_ready unless a new capture occurs on the same edge.
- Simultaneous events: a response handoff, an issue->rsp move and a new accept may all occur on one edge with no bubble.

Test Plan:
- Reset, then A: op3 ra=100 rb=50 -> two edges later rsp_valid=1, id=0, res=127, car=1, zero=0.
- A and B both valid every cycle, a_lock=0 -> grants A,B,A,B. Responses in the same order with matching ids; first grant is A.
- a_lock=1, LOCK_MAX=4, both valid continuously -> 4 A grants, 1 B grant, then 4 A grants again.
- B: op6 ra=5 rb=4 -> jump=0, res=0, zero=1. Then op6 ra=5 rb=1 -> jump=1, res=0, car=0.
- A streams op0 operations while rsp_ready=0 for 3 cycles:
  - first response holds stable throughout;
  - a_ready drops after the second accept;
  - when rsp_ready=1, all results arrive in order with no loss or duplication.
- reset asserted with issue_vld=1 and rsp_vld=1 -> rsp_valid=0 and busy=0 immediately; the discarded op never appears after reset deasserts.

Source files
------------

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Shares one combinational ALU between requester A (execute stage)
//            and requester B (address/branch helper). Round-robin arbitration
//            with a bounded back-to-back lock for A. Accepted operations pass
//            through a registered issue stage, then a registered response
//            stage. ALU outputs that carry no meaning for the opcode are
//            masked off at capture.
// Ports    : clk, reset (async, active-high)
//            a_valid/a_ready/a_op/a_ra/a_rb/a_lock  - requester A
//            b_valid/b_ready/b_op/b_ra/b_rb         - requester B
//            alu_op/alu_ra/alu_rb                   - to ALU
//            alu_res/alu_car/alu_zero/alu_jump      - from ALU
//            rsp_valid/rsp_ready/rsp_id/rsp_res/rsp_car/rsp_zero/rsp_jump
//            busy - an operation is in the issue or response stage
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int REG_WIDTH = 8,
    parameter int OP_WIDTH  = 3,
    parameter int LOCK_MAX  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 a_valid,
    output logic                 a_ready,
    input  logic [OP_WIDTH-1:0]  a_op,
    input  logic [REG_WIDTH-1:0] a_ra,
    input  logic [REG_WIDTH-1:0] a_rb,
    input  logic                 a_lock,
    input  logic                 b_valid,
    output logic                 b_ready,
    input  logic [OP_WIDTH-1:0]  b_op,
    input  logic [REG_WIDTH-1:0] b_ra,
    input  logic [REG_WIDTH-1:0] b_rb,
    output logic [OP_WIDTH-1:0]  alu_op,
    output logic [REG_WIDTH-1:0] alu_ra,
    output logic [REG_WIDTH-1:0] alu_rb,
    input  logic [REG_WIDTH-1:0] alu_res,
    input  logic [REG_WIDTH-1:0] alu_car,
    input  logic                 alu_zero,
    input  logic                 alu_jump,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_id,
    output logic [REG_WIDTH-1:0] rsp_res,
    output logic [REG_WIDTH-1:0] rsp_car,
    output logic                 rsp_zero,
    output logic                 rsp_jump,
    output logic                 busy
);

    localparam int                c_LOCK_W    = $clog2(LOCK_MAX + 1);
    localparam logic [c_LOCK_W-1:0] c_LOCK_MAX = c_LOCK_W'(LOCK_MAX);
    localparam logic [OP_WIDTH-1:0] c_OP_CAR0  = OP_WIDTH'(3);
    localparam logic [OP_WIDTH-1:0] c_OP_CAR1  = OP_WIDTH'(4);
    localparam logic [OP_WIDTH-1:0] c_OP_CAR2  = OP_WIDTH'(5);
    localparam logic [OP_WIDTH-1:0] c_OP_BRCH  = OP_WIDTH'(6);

    // Issue stage
    logic                 r_issue_vld;
    logic                 r_issue_id;
    logic [OP_WIDTH-1:0]  r_issue_op;
    logic [REG_WIDTH-1:0] r_issue_ra;
    logic [REG_WIDTH-1:0] r_issue_rb;
    // Response stage
    logic                 r_rsp_vld;
    logic                 r_rsp_id;
    logic [REG_WIDTH-1:0] r_rsp_res;
    logic [REG_WIDTH-1:0] r_rsp_car;
    logic                 r_rsp_zero;
    logic                 r_rsp_jump;
    // Arbitration state
    logic                 r_last_gnt;     // 0 = A, 1 = B
    logic [c_LOCK_W-1:0]  r_lock_cnt;

    logic                 w_advance;
    logic                 w_can_accept;
    logic                 w_lock_win;
    logic                 w_a_gnt;
    logic                 w_b_gnt;
    logic                 w_a_acc;
    logic                 w_b_acc;
    logic                 w_accept;
    logic                 w_capture;
    logic                 w_car_op;
    logic                 w_is_branch;
    logic [REG_WIDTH-1:0] w_res_m;
    logic [REG_WIDTH-1:0] w_car_m;
    logic                 w_jump_m;
    logic                 w_unused_zero;

    // The zero flag is recomputed from the masked result, so the ALU's own
    // flag would be wrong for branch ops; it is intentionally left unused.
    assign w_unused_zero = alu_zero;

    assign w_advance    = ~r_rsp_vld | rsp_ready;
    assign w_can_accept = ~r_issue_vld | w_advance;
    assign w_lock_win   = a_lock & (r_lock_cnt < c_LOCK_MAX);

    // With both valid, A wins if B went last or A holds an unexpired lock.
    assign w_a_gnt = w_can_accept & a_valid & (~b_valid | w_lock_win | r_last_gnt);
    assign w_b_gnt = w_can_accept & b_valid & ~(a_valid & (w_lock_win | r_last_gnt));

    // Readys are forced low during reset so every output reads 0.
    assign a_ready  = w_a_gnt & ~reset;
    assign b_ready  = w_b_gnt & ~reset;
    assign w_a_acc  = a_valid & a_ready;
    assign w_b_acc  = b_valid & b_ready;
    assign w_accept = w_a_acc | w_b_acc;

    assign w_capture = r_issue_vld & w_advance;

    // Output masking for fields the opcode does not define
    assign w_car_op    = (r_issue_op == c_OP_CAR0) | (r_issue_op == c_OP_CAR1) |
                         (r_issue_op == c_OP_CAR2);
    assign w_is_branch = (r_issue_op == c_OP_BRCH);
    assign w_res_m     = w_is_branch ? '0 : alu_res;
    assign w_car_m     = w_car_op ? alu_car : '0;
    assign w_jump_m    = w_is_branch & alu_jump;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_issue_vld <= 1'b0;
            r_issue_id  <= 1'b0;
            r_issue_op  <= '0;
            r_issue_ra  <= '0;
            r_issue_rb  <= '0;
            r_last_gnt  <= 1'b1;
        end else begin
            if (w_accept) begin
                r_issue_vld <= 1'b1;
                r_issue_id  <= w_b_acc;
                r_issue_op  <= w_b_acc ? b_op : a_op;
                r_issue_ra  <= w_b_acc ? b_ra : a_ra;
                r_issue_rb  <= w_b_acc ? b_rb : a_rb;
                r_last_gnt  <= w_b_acc;
            end else if (w_advance) begin
                r_issue_vld <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lock_cnt <= '0;
        end else if (w_b_acc || !a_lock) begin
            r_lock_cnt <= '0;
        end else if (w_a_acc && b_valid && (r_lock_cnt != c_LOCK_MAX)) begin
            r_lock_cnt <= r_lock_cnt + c_LOCK_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rsp_vld  <= 1'b0;
            r_rsp_id   <= 1'b0;
            r_rsp_res  <= '0;
            r_rsp_car  <= '0;
            r_rsp_zero <= 1'b0;
            r_rsp_jump <= 1'b0;
        end else if (w_capture) begin
            r_rsp_vld  <= 1'b1;
            r_rsp_id   <= r_issue_id;
            r_rsp_res  <= w_res_m;
            r_rsp_car  <= w_car_m;
            r_rsp_zero <= (w_res_m == '0);
            r_rsp_jump <= w_jump_m;
        end else if (rsp_ready) begin
            r_rsp_vld  <= 1'b0;
        end
    end

    assign alu_op    = r_issue_vld ? r_issue_op : '0;
    assign alu_ra    = r_issue_vld ? r_issue_ra : '0;
    assign alu_rb    = r_issue_vld ? r_issue_rb : '0;

    assign rsp_valid = r_rsp_vld;
    assign rsp_id    = r_rsp_id;
    assign rsp_res   = r_rsp_res;
    assign rsp_car   = r_rsp_car;
    assign rsp_zero  = r_rsp_zero;
    assign rsp_jump  = r_rsp_jump;
    assign busy      = r_issue_vld | r_rsp_vld;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Purpose  : Self-checking bench for alu_arbiter with a small ALU stand-in.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

    logic       clk;
    logic       reset;
    logic       a_valid, a_ready, a_lock;
    logic [2:0] a_op;
    logic [7:0] a_ra, a_rb;
    logic       b_valid, b_ready;
    logic [2:0] b_op;
    logic [7:0] b_ra, b_rb;
    logic [2:0] alu_op;
    logic [7:0] alu_ra, alu_rb, alu_res, alu_car;
    logic       alu_zero, alu_jump;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_jump, busy;
    logic [7:0] rsp_res, rsp_car;

    alu_arbiter #(.REG_WIDTH(8), .OP_WIDTH(3), .LOCK_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready), .a_op(a_op), .a_ra(a_ra), .a_rb(a_rb), .a_lock(a_lock),
        .b_valid(b_valid), .b_ready(b_ready), .b_op(b_op), .b_ra(b_ra), .b_rb(b_rb),
        .alu_op(alu_op), .alu_ra(alu_ra), .alu_rb(alu_rb),
        .alu_res(alu_res), .alu_car(alu_car), .alu_zero(alu_zero), .alu_jump(alu_jump),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_res(rsp_res),
        .rsp_car(rsp_car), .rsp_zero(rsp_zero), .rsp_jump(rsp_jump), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU stand-in. Undefined fields carry junk so the arbiter masking shows.
    logic [8:0]  s9;
    logic [8:0]  d9;
    logic [15:0] p16;
    always_comb begin
        alu_res  = '0;
        alu_car  = 8'hA5;
        alu_jump = 1'b1;
        s9  = {alu_ra[7], alu_ra} + {alu_rb[7], alu_rb};
        d9  = {1'b0, alu_ra} - {1'b0, alu_rb};
        p16 = alu_ra * alu_rb;
        case (alu_op)
            3'd0: alu_res = alu_ra + alu_rb;
            3'd1: alu_res = alu_ra - alu_rb;
            3'd2: alu_res = alu_ra & alu_rb;
            3'd3: begin
                if (s9[8] != s9[7]) begin
                    alu_res = s9[8] ? 8'h80 : 8'h7F;
                    alu_car = 8'd1;
                end else begin
                    alu_res = s9[7:0];
                    alu_car = 8'd0;
                end
            end
            3'd4: begin alu_res = d9[7:0]; alu_car = {7'd0, d9[8]}; end
            3'd5: begin alu_res = p16[7:0]; alu_car = p16[15:8]; end
            3'd6: begin alu_res = alu_ra + alu_rb; alu_car = 8'h5A; alu_jump = alu_rb[0]; end
            default: alu_res = alu_ra ^ alu_rb;
        endcase
        alu_zero = (alu_res == 8'd0);
    end

    int n_cmp;
    int n_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        a_valid = 1'b0; b_valid = 1'b0; a_lock = 1'b0;
        a_op = '0; a_ra = '0; a_rb = '0; b_op = '0; b_ra = '0; b_rb = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Scoreboard for op0 (add) streams: expected id/result in accept order.
    typedef struct {
        logic       id;
        logic [7:0] res;
    } exp_t;
    exp_t q[$];
    logic sb_en;

    always @(negedge clk) begin : sb_mon
        exp_t e;
        if (sb_en && !reset) begin
            if (rsp_valid && rsp_ready) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sb_extra: got response id=%0d res=%0h, expected none", rsp_id, rsp_res);
                end else begin
                    e = q.pop_front();
                    chk("sb_id", 32'(rsp_id), 32'(e.id));
                    chk("sb_res", 32'(rsp_res), 32'(e.res));
                    chk("sb_zero", 32'(rsp_zero), 32'(e.res == 8'd0));
                end
            end
            if (a_valid && a_ready) q.push_back('{1'b0, 8'(a_ra + a_rb)});
            if (b_valid && b_ready) q.push_back('{1'b1, 8'(b_ra + b_rb)});
        end
    end

    typedef struct {
        logic       port;
        logic [2:0] op;
        logic [7:0] ra, rb, res, car;
        logic       zero, jump;
    } vec_t;
    vec_t vt[10];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic ga, gb;
        logic [3:0] rr_b;
        logic [9:0] lk_b;
        n_cmp = 0;
        n_err = 0;
        sb_en = 1'b0;

        //        port op   ra     rb     res    car   zero jump
        vt[0] = '{1'b0, 3'd3, 8'd100, 8'd50, 8'd127, 8'd1, 1'b0, 1'b0};
        vt[1] = '{1'b1, 3'd6, 8'd5,   8'd4,  8'd0,   8'd0, 1'b1, 1'b0};
        vt[2] = '{1'b1, 3'd6, 8'd5,   8'd1,  8'd0,   8'd0, 1'b1, 1'b1};
        vt[3] = '{1'b0, 3'd0, 8'd3,   8'd4,  8'd7,   8'd0, 1'b0, 1'b0};
        vt[4] = '{1'b0, 3'd1, 8'd5,   8'd5,  8'd0,   8'd0, 1'b1, 1'b0};
        vt[5] = '{1'b1, 3'd5, 8'd16,  8'd16, 8'd0,   8'd1, 1'b1, 1'b0};
        vt[6] = '{1'b0, 3'd4, 8'd3,   8'd5,  8'hFE,  8'd1, 1'b0, 1'b0};
        vt[7] = '{1'b1, 3'd7, 8'hF0,  8'h0F, 8'hFF,  8'd0, 1'b0, 1'b0};
        vt[8] = '{1'b0, 3'd3, 8'h80,  8'hFF, 8'h80,  8'd1, 1'b0, 1'b0};
        vt[9] = '{1'b1, 3'd2, 8'hF0,  8'h0F, 8'h00,  8'd0, 1'b1, 1'b0};

        // Reset with requests pending: everything must read 0
        reset = 1'b1;
        a_lock = 1'b0; a_op = '0; a_ra = '0; a_rb = '0; b_op = '0; b_ra = '0; b_rb = '0;
        a_valid = 1'b1; b_valid = 1'b1; rsp_ready = 1'b1;
        @(negedge clk);
        chk("rst_a_ready", 32'(a_ready), 32'd0);
        chk("rst_b_ready", 32'(b_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        do_reset();
        @(negedge clk);
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_rsp_res", 32'(rsp_res), 32'd0);
        tick();

        // Single operations, one at a time
        for (int i = 0; i < 10; i++) begin
            if (vt[i].port) begin
                b_valid = 1'b1; b_op = vt[i].op; b_ra = vt[i].ra; b_rb = vt[i].rb;
            end else begin
                a_valid = 1'b1; a_op = vt[i].op; a_ra = vt[i].ra; a_rb = vt[i].rb;
            end
            @(negedge clk);
            chk($sformatf("vec%0d_ready", i), 32'(vt[i].port ? b_ready : a_ready), 32'd1);
            tick();
            a_valid = 1'b0; b_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("vec%0d_early_rsp", i), 32'(rsp_valid), 32'd0);
            chk($sformatf("vec%0d_alu_op", i), 32'(alu_op), 32'(vt[i].op));
            tick();
            @(negedge clk);
            chk($sformatf("vec%0d_rsp_valid", i), 32'(rsp_valid), 32'd1);
            chk($sformatf("vec%0d_id", i), 32'(rsp_id), 32'(vt[i].port));
            chk($sformatf("vec%0d_res", i), 32'(rsp_res), 32'(vt[i].res));
            chk($sformatf("vec%0d_car", i), 32'(rsp_car), 32'(vt[i].car));
            chk($sformatf("vec%0d_zero", i), 32'(rsp_zero), 32'(vt[i].zero));
            chk($sformatf("vec%0d_jump", i), 32'(rsp_jump), 32'(vt[i].jump));
            tick();
        end

        // Round-robin then bounded lock, both requesters always valid
        do_reset();
        q.delete();
        sb_en = 1'b1;
        a_valid = 1'b1; b_valid = 1'b1;
        a_op = 3'd0; a_ra = 8'd1; a_rb = 8'd2;
        b_op = 3'd0; b_ra = 8'h40; b_rb = 8'd1;
        rr_b = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("rr%0d_a", i), 32'(a_ready), 32'(!rr_b[i]));
            chk($sformatf("rr%0d_b", i), 32'(b_ready), 32'(rr_b[i]));
            ga = a_ready; gb = b_ready;
            tick();
            if (ga) a_ra = a_ra + 8'd1;
            if (gb) b_ra = b_ra + 8'd1;
        end
        a_lock = 1'b1;
        lk_b = 10'b10_0001_0000;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("lock%0d_a", i), 32'(a_ready), 32'(!lk_b[i]));
            chk($sformatf("lock%0d_b", i), 32'(b_ready), 32'(lk_b[i]));
            ga = a_ready; gb = b_ready;
            tick();
            if (ga) a_ra = a_ra + 8'd1;
            if (gb) b_ra = b_ra + 8'd1;
        end
        a_valid = 1'b0; b_valid = 1'b0; a_lock = 1'b0;
        repeat (4) tick();
        chk("arb_drain_left", 32'(q.size()), 32'd0);
        chk("arb_drain_busy", 32'(busy), 32'd0);

        // Backpressure: A streams while the consumer stalls
        do_reset();
        q.delete();
        sb_en = 1'b1;
        rsp_ready = 1'b0;
        a_valid = 1'b1; a_op = 3'd0; a_ra = 8'h10; a_rb = 8'd1;
        @(negedge clk);
        chk("bp_acc1", 32'(a_ready), 32'd1);
        tick();
        a_ra = a_ra + 8'd1;
        @(negedge clk);
        chk("bp_acc2", 32'(a_ready), 32'd1);
        tick();
        a_ra = a_ra + 8'd1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("bp_stall%0d_ready", k), 32'(a_ready), 32'd0);
            chk($sformatf("bp_stall%0d_valid", k), 32'(rsp_valid), 32'd1);
            chk($sformatf("bp_stall%0d_res", k), 32'(rsp_res), 32'h11);
            chk($sformatf("bp_stall%0d_id", k), 32'(rsp_id), 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("bp_resume%0d_ready", k), 32'(a_ready), 32'd1);
            ga = a_ready;
            tick();
            if (ga) a_ra = a_ra + 8'd1;
        end
        a_valid = 1'b0;
        repeat (4) tick();
        chk("bp_drain_left", 32'(q.size()), 32'd0);
        chk("bp_drain_busy", 32'(busy), 32'd0);

        // Reset with both stages occupied: nothing may come out afterwards
        sb_en = 1'b0;
        q.delete();
        rsp_ready = 1'b0;
        a_valid = 1'b1; a_op = 3'd0; a_ra = 8'h77; a_rb = 8'd0;
        tick();
        tick();
        a_valid = 1'b0;
        chk("mid_busy", 32'(busy), 32'd1);
        chk("mid_rsp_valid", 32'(rsp_valid), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_alu_op", 32'(alu_ra), 32'd0);
        chk("async_rst_rsp_res", 32'(rsp_res), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("after_rst%0d_rsp_valid", k), 32'(rsp_valid), 32'd0);
        end
        chk("after_rst_busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
